morph_frame_ctrl: RTL

//  Frame-level sequencer for the binary morphology chain (NUM_STAGES cascaded erosion/dilation

---
 rtl/morph_frame_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/morph_frame_ctrl.sv
// Frame-level sequencer for the cascaded binary morphology chain: commits per-stage
// op config at frame start, gates and drains the chain, checks geometry, counts frames.
module morph_frame_ctrl #(
    parameter logic [11:0] IMG_H      = 12'd800,
    parameter logic [11:0] IMG_V      = 12'd600,
    parameter int          NUM_STAGES = 4,
    parameter logic [7:0]  DRAIN_CYC  = 8'd16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    cfg_we,
    input  logic                    cfg_addr,
    input  logic [2*NUM_STAGES-1:0] cfg_wdata,
    input  logic                    pre_vs,
    input  logic                    pre_hs,
    input  logic                    pre_clken,
    output logic [2*NUM_STAGES-1:0] stage_mode,
    output logic                    chain_en,
    output logic                    busy,
    output logic                    cfg_pending,
    output logic                    frame_done,
    output logic [15:0]             frame_cnt,
    output logic                    err_hcnt,
    output logic                    err_vcnt,
    output logic                    err_skip
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN
    } state_t;

    state_t                  state_q;
    logic                    vs_q;
    logic                    hs_q;
    logic [2*NUM_STAGES-1:0] shadow_q;
    logic [11:0]             pix_cnt_q;
    logic [11:0]             line_cnt_q;
    logic [7:0]              drain_cnt_q;

    logic        fs;
    logic        fe;
    logic        le;
    logic        mode_wr;
    logic        err_clr;
    logic [11:0] pix_cnt_d;
    logic [11:0] line_cnt_d;

    assign fs      = pre_vs & ~vs_q;
    assign fe      = ~pre_vs & vs_q;
    assign le      = ~pre_hs & hs_q;
    assign mode_wr = cfg_we & ~cfg_addr;
    assign err_clr = cfg_we & cfg_addr & cfg_wdata[0];

    // Line count already includes a line ending in this cycle, so a frame end that
    // coincides with a line end checks the updated total.
    assign pix_cnt_d  = (pix_cnt_q == 12'hFFF) ? pix_cnt_q : pix_cnt_q + 12'd1;
    assign line_cnt_d = (le && line_cnt_q != 12'hFFF) ? line_cnt_q + 12'd1 : line_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vs_q        <= 1'b1;
            hs_q        <= 1'b0;
            shadow_q    <= '0;
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
            drain_cnt_q <= '0;
            stage_mode  <= '0;
            chain_en    <= 1'b0;
            busy        <= 1'b0;
            cfg_pending <= 1'b0;
            frame_done  <= 1'b0;
            frame_cnt   <= '0;
            err_hcnt    <= 1'b0;
            err_vcnt    <= 1'b0;
            err_skip    <= 1'b0;
        end else begin
            vs_q       <= pre_vs;
            hs_q       <= pre_hs;
            frame_done <= 1'b0;

            if (mode_wr) begin
                shadow_q    <= cfg_wdata;
                cfg_pending <= 1'b1;
            end
            // Clear comes first so an error raised below in the same cycle survives.
            if (err_clr) begin
                err_hcnt <= 1'b0;
                err_vcnt <= 1'b0;
                err_skip <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (fs && enable) begin
                        state_q    <= ACTIVE;
                        stage_mode <= shadow_q;
                        chain_en   <= 1'b1;
                        busy       <= 1'b1;
                        pix_cnt_q  <= '0;
                        line_cnt_q <= '0;
                        if (!mode_wr) begin
                            cfg_pending <= 1'b0;
                        end
                    end
                end
                ACTIVE: begin
                    if (pre_clken && pre_hs) begin
                        pix_cnt_q <= pix_cnt_d;
                    end
                    if (le) begin
                        if (pix_cnt_q != IMG_H) begin
                            err_hcnt <= 1'b1;
                        end
                        line_cnt_q <= line_cnt_d;
                        pix_cnt_q  <= '0;
                    end
                    if (fe) begin
                        if (line_cnt_d != IMG_V) begin
                            err_vcnt <= 1'b1;
                        end
                        drain_cnt_q <= DRAIN_CYC - 8'd1;
                        state_q     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fs) begin
                        err_skip <= 1'b1;
                    end
                    if (drain_cnt_q == 8'd0) begin
                        state_q    <= IDLE;
                        chain_en   <= 1'b0;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    chain_en <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
